// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clk cycles and publishes the count.
// Optional macro FREQ_METER_SAT_EN: saturating edge counter with a per-window overflow flag on ovf.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned GATE_W      = 29,
  parameter int unsigned CNT_W       = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic {ST_IDLE, ST_MEASURE} state_t;

  localparam logic [GATE_W-1:0] LP_GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_s1, r_s2, r_s3;
  logic              w_rise;
  logic              w_measure;
  logic              w_end;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic [CNT_W-1:0]  w_edge_next;
  logic [CNT_W-1:0]  r_freq;
  logic              r_valid;

  // Synchronizer plus history flop run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (en)  w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (!en) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_measure = (r_state == ST_MEASURE);
  // The end cycle publishes even if en drops on that same cycle.
  assign w_end     = w_measure && (r_gate_cnt == LP_GATE_LAST);

`ifdef FREQ_METER_SAT_EN
  logic w_sat_hit;
  logic r_flag;
  logic r_ovf;

  assign w_sat_hit   = w_rise & (&r_edge_cnt);
  assign w_edge_next = w_sat_hit ? r_edge_cnt : r_edge_cnt + CNT_W'(w_rise);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_end) r_ovf <= r_flag | w_sat_hit;
      if (w_measure && en && !w_end) r_flag <= r_flag | w_sat_hit;
      else                           r_flag <= 1'b0;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_edge_next = r_edge_cnt + CNT_W'(w_rise);
  assign ovf         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= w_end;
      if (w_end) begin
        r_freq     <= w_edge_next;
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
      end else if (w_measure && en) begin
        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
        r_edge_cnt <= w_edge_next;
      end else begin
        r_gate_cnt <= '0;
        r_edge_cnt <= '0;
      end
    end
  end

  assign freq_out   = r_freq;
  assign freq_valid = r_valid;
  assign busy       = w_measure;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: scoreboard queues of expected window counts, popped on freq_valid.
`timescale 1ns/1ps
module tb_freq_meter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       en_o;
  logic       sig_sync;
  logic       sig_async;
  logic       async_on;
  wire        w_sig = async_on ? sig_async : sig_sync;

  logic [7:0] freq_out;
  logic       freq_valid;
  logic       busy;
  logic       ovf;
  logic [2:0] freq_out_o;
  logic       freq_valid_o;
  logic       busy_o;
  logic       ovf_o;

  logic [7:0] exp_q[$];
  logic [3:0] exp_o_q[$];
  int         n_vec;
  int         n_err;
  int         ph;
  int         async_wins;
  logic       prev_valid;

  freq_meter #(.GATE_CYCLES(100), .GATE_W(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(w_sig),
    .freq_out(freq_out), .freq_valid(freq_valid), .busy(busy), .ovf(ovf)
  );

  freq_meter #(.GATE_CYCLES(100), .GATE_W(8), .CNT_W(3)) u_ovf (
    .clk(clk), .rst_n(rst_n), .en(en_o), .sig_in(w_sig),
    .freq_out(freq_out_o), .freq_valid(freq_valid_o), .busy(busy_o), .ovf(ovf_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n cycles; drive a square wave of the given period when period > 0.
  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (period > 0) begin
        sig_sync = ((ph % period) < (period / 2));
        ph++;
      end
    end
  endtask

  // Free-running asynchronous source: 146 ns period (7.3 clk) with random phase.
  initial begin
    sig_async = 1'b0;
    wait (async_on);
    #($urandom_range(0, 145));
    forever begin
      #73 sig_async = ~sig_async;
    end
  end

  // Scoreboard for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (freq_valid && prev_valid) check("valid_width", 1, 0);
      if (freq_valid) begin
        if (async_on) begin
          check("async_no_x", {31'd0, $isunknown(freq_out)}, 0);
          check("async_range", {31'd0, (freq_out == 8'd13) || (freq_out == 8'd14)}, 1);
          async_wins++;
        end else if (exp_q.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          check("freq_out", freq_out, exp_q.pop_front());
          check("ovf_main", ovf, 0);
        end
      end
    end
    prev_valid = freq_valid;
  end

  // Scoreboard for the 3-bit overflow instance
  always @(negedge clk) begin
    if (rst_n && freq_valid_o) begin
      if (exp_o_q.size() == 0) begin
        check("spurious_valid_o", 1, 0);
      end else begin
        logic [3:0] e;
        e = exp_o_q.pop_front();
        check("ovf_freq", freq_out_o, e[2:0]);
        check("ovf_flag", ovf_o, e[3]);
      end
    end
  end

  initial begin
    n_vec = 0; n_err = 0; ph = 0; async_wins = 0; prev_valid = 1'b0;
    rst_n = 1'b0; en = 1'b0; en_o = 1'b0; sig_sync = 1'b0; async_on = 1'b0;

    // Reset with the input toggling, then idle with en low
    run(10, 4);
    check("rst_freq", freq_out, 0);
    check("rst_valid", freq_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_freq_o", freq_out_o, 0);
    rst_n = 1'b1;
    run(500, 10);
    check("idle_busy", busy, 0);

    // Basic count: period 10 -> 10 per window, three windows
    en = 1'b1;
    repeat (3) exp_q.push_back(8'd10);
    run(50, 10);
    check("busy_measure", busy, 1);
    run(255, 10);
    en = 1'b0;
    run(20, 10);
    check("idle_after", busy, 0);

    // Abort mid-window: no publish, freq_out holds
    en = 1'b1;
    run(50, 10);
    en = 1'b0;
    run(20, 10);
    check("abort_hold", freq_out, 10);
    check("abort_busy", busy, 0);
    en = 1'b1;
    exp_q.push_back(8'd10);
    run(105, 10);
    en = 1'b0;
    run(10, 10);

    // Boundary: single rise lands on the end cycle of window 1
    sig_sync = 1'b0;
    run(10, 0);
    en = 1'b1;
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    run(98, 0);
    sig_sync = 1'b1;
    run(107, 0);
    en = 1'b0;
    sig_sync = 1'b0;
    run(10, 0);
    check("boundary_last", freq_out, 0);

    // Overflow: period 4 -> 25 edges into a 3-bit counter
    en_o = 1'b1;
`ifdef FREQ_METER_SAT_EN
    repeat (2) exp_o_q.push_back({1'b1, 3'd7});
`else
    repeat (2) exp_o_q.push_back({1'b0, 3'd1});
`endif
    run(205, 4);
    en_o = 1'b0;
    run(10, 4);

    // Asynchronous input, 7.3 clk period -> 13 or 14 per 100-cycle window
    async_on = 1'b1;
    run(10, 0);
    async_wins = 0;
    en = 1'b1;
    run(405, 0);
    en = 1'b0;
    run(10, 0);
    async_on = 1'b0;
    check("async_windows", async_wins, 4);

    // Reset mid-window clears everything without publishing
    sig_sync = 1'b0;
    en = 1'b1;
    run(50, 10);
    rst_n = 1'b0;
    #1;
    check("midrst_freq", freq_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", freq_valid, 0);
    en = 1'b0;
    run(3, 10);
    rst_n = 1'b1;
    run(150, 10);
    check("post_rst_busy", busy, 0);

    check("drain_main", exp_q.size(), 0);
    check("drain_ovf", exp_o_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter and the measuring counterpart of the team's N-divider blocks.
- Counts rising edges of an asynchronous input over a fixed gate window derived from the 50 MHz system clock (default 1 s), then publishes the count as Hz.
- Used to check divider outputs and external clock/button sources on the board.
- Runs back-to-back windows continuously while enabled.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); must be >= 4.
- GATE_W, 29, width of the gate counter; must hold GATE_CYCLES-1.
- CNT_W, 26, width of the edge counter and freq_out.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  measurement enable, synchronous to clk.
- sig_in  input  1  signal under measurement, asynchronous to clk.
- freq_out  output  CNT_W  edge count of the last completed window.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- busy  output  1  high while in MEASURE.
- ovf  output  1  last published window overflowed (see Optional Feature).

Behaviour:
- Reset (rst_n low, async): state=IDLE; sync/edge flops=0; gate_cnt=0; edge_cnt=0; freq_out=0; freq_valid=0; busy=0; ovf=0.
- Input path: 2-flop synchronizer (s1, s2), then a history flop s3. These always run, regardless of state.
- rise = s2 & ~s3. A sig_in 0->1 transition appears as rise 2-3 clk later.
- Only pulses longer than one clk period in each level are guaranteed to count.
- IDLE:
  - busy=0; gate_cnt and edge_cnt held at 0; freq_out and ovf hold their last values.
  - en=1 -> MEASURE next cycle, with gate_cnt=0.
- MEASURE:
  - busy=1.
  - Each cycle: gate_cnt += 1; edge_cnt += rise.
  - When gate_cnt == GATE_CYCLES-1 (end cycle):
    - freq_out <= edge_cnt + rise, so a rise on the end cycle counts in the closing window.
    - freq_valid <= 1 for exactly the next cycle.
    - gate_cnt <= 0; edge_cnt <= 0.
    - The next window starts immediately, with no dead cycle.
  - en=0 at any point: go to IDLE next cycle.
    - The window is aborted; freq_out, ovf and freq_valid are not updated.
    - If en drops on the end cycle itself, that window still publishes.
- Window length is exactly GATE_CYCLES clk cycles, so freq_out at the default equals Hz.
- Latency: freq_valid is asserted in the first cycle of the following window.
- Reset mid-window: all state clears immediately; no partial result is published.
- Width rule: edge_cnt and freq_out are CNT_W unsigned. Behaviour on exceeding 2^CNT_W-1 is defined by the Optional Feature.

Optional Feature:
- Macro: FREQ_METER_SAT_EN.
- Defined:
  - edge_cnt saturates at 2^CNT_W-1.
  - An internal sticky flag is set on any increment attempted at the max value.
  - At window end, ovf <= flag; the flag then clears.
- Not defined:
  - edge_cnt wraps modulo 2^CNT_W.
  - ovf is tied to 0.
  - No saturation logic is synthesized.

Test Plan:
- Reset/idle: rst_n low with sig_in toggling -> all outputs 0; release with en=0 for 500 cycles -> busy=0, freq_valid never pulses.
- Basic count (GATE_CYCLES=100, CNT_W=8): en=1, sig_in period 10 clk -> freq_valid pulses every 100 cycles, freq_out=10 each window; busy=1 throughout.
- Boundary edge: align a single sig_in rise so rise hits the end cycle of window k -> counted in window k (freq_out=1), window k+1 reports 0.
- Abort: en=1, sig_in period 10, drop en at gate_cnt=50 -> no freq_valid, freq_out keeps the prior value; re-raise en -> first result appears 100 cycles later, =10.
- Overflow (GATE_CYCLES=100, CNT_W=3, sig_in period 4, 25 edges): with FREQ_METER_SAT_EN -> freq_out=7, ovf=1; without -> freq_out=1 (25 mod 8), ovf=0.
- Async input: sig_in period 7.3 clk with random phase to clk, GATE_CYCLES=1000 -> freq_out in {136,137} every window, no X, no missed windows.
